// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM model: LANES parallel 4-bit chips sharing sck/cs, decoding
// READ (0x03) and WRITE (0x02), with a backdoor port for preload and inspection.
module idli_sqi_mem_m #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 17,
    parameter int DUMMY  = 2
) (
    input  logic                 i_mem_gck,
    input  logic                 i_mem_rst,
    input  logic                 i_mem_sck,
    input  logic                 i_mem_cs,
    input  logic [4*LANES-1:0]   i_mem_sio,
    output logic [4*LANES-1:0]   o_mem_sio,
    output logic                 o_mem_oe,
    output logic                 o_mem_err,
    input  logic                 i_mem_bd_en,
    input  logic                 i_mem_bd_we,
    input  logic [ADDR_W-1:0]    i_mem_bd_addr,
    input  logic [8*LANES-1:0]   i_mem_bd_wdata,
    output logic [8*LANES-1:0]   o_mem_bd_rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_RDATA = 3'd4,
        ST_WDATA = 3'd5,
        ST_SKIP  = 3'd6
    } state_t;

    logic [7:0]           mem_r [LANES][DEPTH];

    state_t               state_r, state_s;
    logic [7:0]           cnt_r, cnt_s;
    logic                 is_read_r, is_read_s;
    logic [3:0]           cmd_hi_r, cmd_hi_s;
    logic [ADDR_W-1:0]    addr_r, addr_s;
    logic                 lo_r, lo_s;
    logic [4*LANES-1:0]   whi_r, whi_s;
    logic [4*LANES-1:0]   sio_r, sio_s;
    logic                 oe_r, oe_s;
    logic                 err_r, err_s;
    logic [8*LANES-1:0]   bd_rdata_r;

    logic                 beat_s;
    logic                 mismatch_s;
    logic                 hdr_state_s;
    logic                 bd_wr_s;
    logic                 sqi_we_s;
    logic [ADDR_W-1:0]    shift_addr_s;
    logic [ADDR_W-1:0]    rd_addr_s;
    logic [4*LANES-1:0]   rd_hi_s, rd_lo_s;
    logic [8*LANES-1:0]   bd_rd_s;

    assign beat_s       = ~i_mem_cs & i_mem_sck;
    assign bd_wr_s      = i_mem_bd_en & i_mem_bd_we;
    assign hdr_state_s  = (state_r == ST_IDLE) | (state_r == ST_CMD) | (state_r == ST_ADDR);
    // Address nibbles shift in MSB first; truncation keeps only the low ADDR_W bits.
    assign shift_addr_s = ADDR_W'({addr_r, i_mem_sio[3:0]});

    // Detect a lane whose nibble disagrees with lane 0.
    always_comb begin
        mismatch_s = 1'b0;
        for (int l = 1; l < LANES; l++) begin
            mismatch_s = mismatch_s | (i_mem_sio[4*l +: 4] != i_mem_sio[3:0]);
        end
    end

    // Select the address whose byte is presented on the next registered output.
    always_comb begin
        if (state_r == ST_ADDR) begin
            rd_addr_s = shift_addr_s;
        end else if ((state_r == ST_RDATA) && lo_r) begin
            rd_addr_s = addr_r + ADDR_ONE;
        end else begin
            rd_addr_s = addr_r;
        end
    end

    // Split each lane's byte into high/low nibble buses; also form backdoor read data.
    always_comb begin
        rd_hi_s = {(4*LANES){1'b0}};
        rd_lo_s = {(4*LANES){1'b0}};
        bd_rd_s = {(8*LANES){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            rd_hi_s[4*l +: 4] = mem_r[l][rd_addr_s][7:4];
            rd_lo_s[4*l +: 4] = mem_r[l][rd_addr_s][3:0];
            bd_rd_s[8*l +: 8] = mem_r[l][i_mem_bd_addr];
        end
    end

    // Protocol FSM next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        is_read_s = is_read_r;
        cmd_hi_s  = cmd_hi_r;
        addr_s    = addr_r;
        lo_s      = lo_r;
        whi_s     = whi_r;
        sio_s     = sio_r;
        sqi_we_s  = 1'b0;
        err_s     = err_r | (beat_s & hdr_state_s & mismatch_s);

        if (i_mem_cs) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            lo_s    = 1'b0;
            sio_s   = {(4*LANES){1'b0}};
        end else if (beat_s) begin
            case (state_r)
                ST_IDLE: begin
                    cmd_hi_s = i_mem_sio[3:0];
                    state_s  = ST_CMD;
                end
                ST_CMD: begin
                    cnt_s = 8'd0;
                    case ({cmd_hi_r, i_mem_sio[3:0]})
                        8'h03: begin
                            is_read_s = 1'b1;
                            state_s   = ST_ADDR;
                        end
                        8'h02: begin
                            is_read_s = 1'b0;
                            state_s   = ST_ADDR;
                        end
                        default: begin
                            state_s = ST_SKIP;
                            err_s   = 1'b1;
                        end
                    endcase
                end
                ST_ADDR: begin
                    addr_s = shift_addr_s;
                    if (cnt_r == 8'd5) begin
                        cnt_s = 8'd0;
                        lo_s  = 1'b0;
                        if (!is_read_r) begin
                            state_s = ST_WDATA;
                        end else if (DUMMY == 0) begin
                            state_s = ST_RDATA;
                            sio_s   = rd_hi_s;
                        end else begin
                            state_s = ST_DUMMY;
                        end
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                ST_DUMMY: begin
                    if (cnt_r == 8'(DUMMY - 1)) begin
                        cnt_s   = 8'd0;
                        lo_s    = 1'b0;
                        state_s = ST_RDATA;
                        sio_s   = rd_hi_s;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (!lo_r) begin
                        sio_s = rd_lo_s;
                        lo_s  = 1'b1;
                    end else begin
                        addr_s = addr_r + ADDR_ONE;
                        sio_s  = rd_hi_s;
                        lo_s   = 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (!lo_r) begin
                        whi_s = i_mem_sio;
                        lo_s  = 1'b1;
                    end else begin
                        sqi_we_s = 1'b1;
                        addr_s   = addr_r + ADDR_ONE;
                        lo_s     = 1'b0;
                    end
                end
                ST_SKIP: begin
                    state_s = ST_SKIP;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // A same-cycle backdoor write takes the memory; the SQI byte is lost.
        err_s = err_s | (sqi_we_s & bd_wr_s);
        oe_s  = (state_s == ST_RDATA);
    end

    // FSM and output registers.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            is_read_r  <= 1'b0;
            cmd_hi_r   <= 4'd0;
            addr_r     <= {ADDR_W{1'b0}};
            lo_r       <= 1'b0;
            whi_r      <= {(4*LANES){1'b0}};
            sio_r      <= {(4*LANES){1'b0}};
            oe_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            is_read_r  <= is_read_s;
            cmd_hi_r   <= cmd_hi_s;
            addr_r     <= addr_s;
            lo_r       <= lo_s;
            whi_r      <= whi_s;
            sio_r      <= sio_s;
            oe_r       <= oe_s;
            err_r      <= err_s;
        end
    end

    // Backdoor read data register.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            bd_rdata_r <= {(8*LANES){1'b0}};
        end else if (i_mem_bd_en && !i_mem_bd_we) begin
            bd_rdata_r <= bd_rd_s;
        end else begin
            bd_rdata_r <= bd_rdata_r;
        end
    end

    // Storage is never reset; backdoor writes have priority over SQI writes.
    always_ff @(posedge i_mem_gck) begin
        if (bd_wr_s) begin
            for (int l = 0; l < LANES; l++) begin
                mem_r[l][i_mem_bd_addr] <= i_mem_bd_wdata[8*l +: 8];
            end
        end else if (sqi_we_s && !i_mem_rst) begin
            for (int l = 0; l < LANES; l++) begin
                mem_r[l][addr_r] <= {whi_r[4*l +: 4], i_mem_sio[4*l +: 4]};
            end
        end
    end

    assign o_mem_sio      = sio_r;
    assign o_mem_oe       = oe_r;
    assign o_mem_err      = err_r;
    assign o_mem_bd_rdata = bd_rdata_r;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Randomized bench for idli_sqi_mem_m against a transaction-level memory model.
module tb_idli_sqi_mem_m;

    localparam int LANES  = 2;
    localparam int ADDR_W = 8;
    localparam int DUMMY  = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NW     = 4 * LANES;
    localparam int BW     = 8 * LANES;

    logic              clk = 1'b0;
    logic              rst;
    logic              sck;
    logic              cs;
    logic [NW-1:0]     sio_in;
    logic [NW-1:0]     sio_out;
    logic              oe;
    logic              err;
    logic              bd_en;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [BW-1:0]     bd_wdata;
    logic [BW-1:0]     bd_rdata;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] mdl [DEPTH];
    logic [BW-1:0] wq [$];

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.LANES(LANES), .ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
        .i_mem_gck      (clk),
        .i_mem_rst      (rst),
        .i_mem_sck      (sck),
        .i_mem_cs       (cs),
        .i_mem_sio      (sio_in),
        .o_mem_sio      (sio_out),
        .o_mem_oe       (oe),
        .o_mem_err      (err),
        .i_mem_bd_en    (bd_en),
        .i_mem_bd_we    (bd_we),
        .i_mem_bd_addr  (bd_addr),
        .i_mem_bd_wdata (bd_wdata),
        .o_mem_bd_rdata (bd_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] rep(input logic [3:0] n);
        return {LANES{n}};
    endfunction

    function automatic logic [NW-1:0] nibs(input logic [BW-1:0] w, input bit hi);
        logic [NW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[4*l +: 4] = hi ? w[8*l + 4 +: 4] : w[8*l +: 4];
        end
        return r;
    endfunction

    task automatic drive(input logic cs_v, input logic sck_v, input logic [NW-1:0] v);
        cs = cs_v;
        sck = sck_v;
        sio_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [NW-1:0] v);
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, NW'($urandom));
        drive(1'b0, 1'b1, v);
    endtask

    task automatic deselect();
        drive(1'b1, 1'b0, NW'($urandom));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b1, 1'b0, {NW{1'b0}});
        rst = 1'b0;
    endtask

    task automatic send_hdr(input logic [3:0] c_lo, input logic [ADDR_W-1:0] a);
        logic [23:0] a24;
        a24 = 24'($urandom);
        a24[ADDR_W-1:0] = a;
        beat(rep(4'h0));
        beat(rep(c_lo));
        for (int k = 5; k >= 0; k--) beat(rep(a24[4*k +: 4]));
    endtask

    task automatic bd_wr(input logic [ADDR_W-1:0] a, input logic [BW-1:0] d);
        bd_en = 1'b1; bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(posedge clk);
        #1;
        bd_en = 1'b0; bd_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic bd_rd_chk(input string tag, input logic [ADDR_W-1:0] a);
        bd_en = 1'b1; bd_we = 1'b0; bd_addr = a;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
        check(tag, bd_rdata, mdl[a]);
    endtask

    // Writes the bytes in wq starting at a; optional backdoor collision on the last byte.
    task automatic sqi_write(input logic [ADDR_W-1:0] a, input bit collide,
                             input logic [ADDR_W-1:0] ca, input logic [BW-1:0] cd);
        int n;
        n = wq.size();
        send_hdr(4'h2, a);
        for (int i = 0; i < n; i++) begin
            beat(nibs(wq[i], 1'b1));
            check("wr_oe", oe, 1'b0);
            if (collide && i == n - 1) begin
                bd_en = 1'b1; bd_we = 1'b1; bd_addr = ca; bd_wdata = cd;
                drive(1'b0, 1'b1, nibs(wq[i], 1'b0));
                bd_en = 1'b0; bd_we = 1'b0;
                mdl[ca] = cd;
            end else begin
                beat(nibs(wq[i], 1'b0));
                mdl[ADDR_W'(a + ADDR_W'(i))] = wq[i];
            end
            check("wr_oe", oe, 1'b0);
        end
        deselect();
    endtask

    task automatic sqi_read(input logic [ADDR_W-1:0] a, input int n);
        logic [BW-1:0] w;
        send_hdr(4'h3, a);
        for (int d = 0; d < DUMMY; d++) beat(NW'($urandom));
        for (int i = 0; i < n; i++) begin
            w = mdl[ADDR_W'(a + ADDR_W'(i))];
            check("rd_oe_hi", oe, 1'b1);
            check("rd_sio_hi", sio_out, nibs(w, 1'b1));
            beat(NW'($urandom));
            check("rd_oe_lo", oe, 1'b1);
            check("rd_sio_lo", sio_out, nibs(w, 1'b0));
            beat(NW'($urandom));
        end
        deselect();
        check("rd_oe_off", oe, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_in = {NW{1'b0}};
        bd_en = 1'b0; bd_we = 1'b0; bd_addr = {ADDR_W{1'b0}}; bd_wdata = {BW{1'b0}};
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", oe, 1'b0);
        check("rst_sio", sio_out, {NW{1'b0}});
        check("rst_err", err, 1'b0);
        check("rst_bd", bd_rdata, {BW{1'b0}});
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) bd_wr(ADDR_W'(a), BW'($urandom));

        // SQI write then backdoor inspection
        wq = {};
        wq.push_back(16'h12A5);
        wq.push_back(16'h343C);
        sqi_write(8'h10, 1'b0, 8'h00, 16'h0000);
        bd_rd_chk("wr_10", 8'h10);
        check("wr_10_const", bd_rdata, 16'h12A5);
        bd_rd_chk("wr_11", 8'h11);
        check("wr_11_const", bd_rdata, 16'h343C);
        check("wr_err", err, 1'b0);

        // Backdoor preload, SQI read
        bd_wr(8'h20, 16'hBEEF);
        sqi_read(8'h20, 1);

        // Read across the top of the address space
        bd_wr(8'hFF, 16'h1111);
        bd_wr(8'h00, 16'h2222);
        sqi_read(8'hFF, 2);

        // Abort after one data nibble
        send_hdr(4'h2, 8'h30);
        beat(rep(4'h7));
        deselect();
        check("abort_oe", oe, 1'b0);
        bd_rd_chk("abort_mem", 8'h30);
        sqi_read(8'h30, 1);
        check("abort_err", err, 1'b0);

        // Unknown command
        beat(rep(4'h0));
        beat(rep(4'h5));
        check("badcmd_err", err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(NW'($urandom));
            check("badcmd_oe", oe, 1'b0);
        end
        deselect();
        check("badcmd_sticky", err, 1'b1);
        reset_dut();
        check("rst2_err", err, 1'b0);

        // Lane disagreement in the command
        beat({4'h1, 4'h0});
        check("lane_err", err, 1'b1);
        deselect();
        reset_dut();

        // Backdoor and SQI write collide
        wq = {};
        wq.push_back(BW'($urandom));
        sqi_write(8'h40, 1'b1, 8'h41, 16'h5A5A);
        check("coll_err", err, 1'b1);
        bd_rd_chk("coll_40", 8'h40);
        bd_rd_chk("coll_41", 8'h41);
        reset_dut();

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] a;
            int n;
            a = ADDR_W'($urandom);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                wq = {};
                for (int i = 0; i < n; i++) wq.push_back(BW'($urandom));
                sqi_write(a, 1'b0, 8'h00, 16'h0000);
            end else begin
                sqi_read(a, n);
            end
            bd_rd_chk("rnd_bd", ADDR_W'($urandom));
            check("rnd_err", err, 1'b0);
        end

        // Reset during RDATA, with err set by a lane disagreement in the address
        beat(rep(4'h0));
        beat(rep(4'h3));
        beat({4'hF, 4'h0});
        for (int k = 4; k >= 0; k--) beat(rep(5'(k) == 5'd1 ? 4'h5 : 4'h0));
        for (int d = 0; d < DUMMY; d++) beat(NW'($urandom));
        check("rmid_err_pre", err, 1'b1);
        check("rmid_sio_pre", sio_out, nibs(mdl[8'h50], 1'b1));
        beat(NW'($urandom));
        check("rmid_oe_pre", oe, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b1, NW'($urandom));
        rst = 1'b0;
        check("rmid_oe", oe, 1'b0);
        check("rmid_sio", sio_out, {NW{1'b0}});
        check("rmid_err", err, 1'b0);
        deselect();
        bd_rd_chk("rmid_mem", 8'h50);
        sqi_read(8'h50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
